// File: rtl/sd4_operand_loader.sv
// SD4 operand loader: packs (image, weight) beats into 9-element vectors.
// Optional SD4_LOADER_VEC_COUNT_EN adds a 16-bit output handshake counter.
module sd4_operand_loader #(
  parameter int ELEMS = 9,
  parameter int IMG_W = 8,
  parameter int WGT_W = 4,
  parameter int EXP_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IMG_W-1:0]       in_image,
  input  logic [WGT_W-1:0]       in_weight,
  input  logic                   cfg_we,
  input  logic [EXP_W-1:0]       cfg_exp_bias,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ELEMS*IMG_W-1:0] out_image,
  output logic [ELEMS*WGT_W-1:0] out_weight,
  output logic [EXP_W-1:0]       out_exp_bias
`ifdef SD4_LOADER_VEC_COUNT_EN
  ,
  output logic [15:0]            vec_count
`endif
);

  localparam int CW = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam logic [CW-1:0] LAST = CW'(ELEMS - 1);

  logic [CW-1:0]          cnt;
  logic [ELEMS*IMG_W-1:0] img_buf;
  logic [ELEMS*WGT_W-1:0] wgt_buf;
  logic [ELEMS*IMG_W-1:0] img_nxt;
  logic [ELEMS*WGT_W-1:0] wgt_nxt;
  logic [EXP_W-1:0]       bias_q;
  logic                   is_last;
  logic                   accept;
  logic                   done;

  assign is_last  = (cnt == LAST);
  // Only the completion beat can collide with an unconsumed vector.
  assign in_ready = !clear && !(is_last && out_valid && !out_ready);
  assign accept   = in_valid && in_ready;
  assign done     = accept && is_last;

  always_comb begin
    img_nxt = img_buf;
    wgt_nxt = wgt_buf;
    img_nxt[cnt*IMG_W +: IMG_W] = in_image;
    wgt_nxt[cnt*WGT_W +: WGT_W] = in_weight;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      img_buf <= '0;
      wgt_buf <= '0;
    end else if (clear) begin
      cnt     <= '0;
      img_buf <= '0;
      wgt_buf <= '0;
    end else if (accept) begin
      if (is_last) begin
        cnt     <= '0;
        img_buf <= '0;
        wgt_buf <= '0;
      end else begin
        cnt     <= cnt + 1'b1;
        img_buf <= img_nxt;
        wgt_buf <= wgt_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid    <= 1'b0;
      out_image    <= '0;
      out_weight   <= '0;
      out_exp_bias <= '0;
    end else if (done) begin
      out_valid    <= 1'b1;
      out_image    <= img_nxt;
      out_weight   <= wgt_nxt;
      out_exp_bias <= bias_q;
    end else if (out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bias_q <= '0;
    end else if (cfg_we) begin
      bias_q <= cfg_exp_bias;
    end
  end

`ifdef SD4_LOADER_VEC_COUNT_EN
  logic [15:0] vcnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vcnt_q <= '0;
    end else if (out_valid && out_ready) begin
      vcnt_q <= vcnt_q + 16'd1;
    end
  end

  assign vec_count = vcnt_q;
`endif

endmodule

// File: tb/tb_sd4_operand_loader.sv
// Scoreboard bench for sd4_operand_loader: directed plan plus random traffic.
// Reference model keeps pending elements in queues and builds vectors arithmetically.
module tb_sd4_operand_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_image = '0;
  logic [3:0]  in_weight = '0;
  logic        cfg_we = 1'b0;
  logic [4:0]  cfg_exp_bias = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [71:0] out_image;
  logic [35:0] out_weight;
  logic [4:0]  out_exp_bias;
`ifdef SD4_LOADER_VEC_COUNT_EN
  logic [15:0] vec_count;
`endif

  sd4_operand_loader dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_image     (in_image),
    .in_weight    (in_weight),
    .cfg_we       (cfg_we),
    .cfg_exp_bias (cfg_exp_bias),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_image    (out_image),
    .out_weight   (out_weight),
    .out_exp_bias (out_exp_bias)
`ifdef SD4_LOADER_VEC_COUNT_EN
    ,
    .vec_count    (vec_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [71:0] img;
    logic [35:0] wgt;
    logic [4:0]  bias;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  vec_t expq[$];
  logic [7:0] img_q[$];
  logic [3:0] wgt_q[$];
  bit   mvalid = 0;
  logic [4:0] mbias = '0;
  int   hs_cnt = 0;

  task automatic chk(input string nm, input logic [71:0] act,
                     input logic [71:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    img_q.delete();
    wgt_q.delete();
    expq.delete();
    mvalid = 0;
    mbias = '0;
    hs_cnt = 0;
  endtask

  task automatic step(input bit iv, input logic [7:0] im,
                      input logic [3:0] wg, input bit clr,
                      input bit we, input logic [4:0] cb,
                      input bit ordy, output bit acc);
    bit   exp_rdy;
    bit   consumed;
    vec_t v;
    @(negedge clk);
    in_valid = iv;
    in_image = im;
    in_weight = wg;
    clear = clr;
    cfg_we = we;
    cfg_exp_bias = cb;
    out_ready = ordy;
    #1;
    exp_rdy = !clr && !(img_q.size() == 8 && mvalid && !ordy);
    chk("in_ready", 72'(in_ready), 72'(exp_rdy));
    chk("out_valid", 72'(out_valid), 72'(mvalid));
    acc = iv && exp_rdy;
    consumed = mvalid && ordy;
    if (clr) begin
      img_q.delete();
      wgt_q.delete();
    end
    if (acc) begin
      img_q.push_back(im);
      wgt_q.push_back(wg);
    end
    if (img_q.size() == 9) begin
      v.img = '0;
      v.wgt = '0;
      for (int k = 0; k < 9; k++) begin
        v.img = v.img | (72'(img_q[k]) << (8 * k));
        v.wgt = v.wgt | (36'(wgt_q[k]) << (4 * k));
      end
      v.bias = mbias;
      expq.push_back(v);
      img_q.delete();
      wgt_q.delete();
      mvalid = 1;
    end else if (consumed) begin
      mvalid = 0;
    end
    if (we) mbias = cb;
  endtask

  task automatic idle(input bit ordy);
    bit a;
    step(0, '0, '0, 0, 0, '0, ordy, a);
  endtask

  task automatic send(input logic [7:0] im, input logic [3:0] wg);
    bit a;
    int n;
    a = 0;
    n = 0;
    while (!a && n < 20) begin
      step(1, im, wg, 0, 0, '0, 1, a);
      n++;
    end
    if (!a) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 0;
    in_valid = 0;
    clear = 0;
    cfg_we = 0;
    repeat (cycles) @(negedge clk);
    #1;
    model_reset();
    chk("rst_out_valid", 72'(out_valid), 72'(0));
    chk("rst_out_image", out_image, 72'(0));
    chk("rst_out_weight", 72'(out_weight), 72'(0));
    chk("rst_out_bias", 72'(out_exp_bias), 72'(0));
    rst = 1;
  endtask

  always @(negedge clk) begin
    vec_t e;
    #2;
    if (rst && out_valid && out_ready) begin
      hs_cnt++;
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_vector: got %h expected none", out_image);
      end else begin
        e = expq.pop_front();
        chk("vec_image", out_image, e.img);
        chk("vec_weight", 72'(out_weight), 72'(e.wgt));
        chk("vec_bias", 72'(out_exp_bias), 72'(e.bias));
      end
    end
  end

  initial begin
    bit a;
    int n;
    model_reset();
    do_reset(2);
    // Test 1: counting pattern with bias 12.
    step(0, '0, '0, 0, 1, 5'd12, 1, a);
    for (int k = 0; k < 9; k++) send(8'(k + 1), 4'(k));
    idle(1);
    chk("tp1_image", out_image, 72'h090807060504030201);
    chk("tp1_weight", 72'(out_weight), 72'h876543210);
    chk("tp1_bias", 72'(out_exp_bias), 72'd12);
    chk("tp1_valid", 72'(out_valid), 72'd1);
    // Test 2: held output with double buffering and stall.
    for (int k = 0; k < 9; k++) step(1, 8'(8'h10 + k), 4'(k), 0, 0, '0, 0, a);
    for (int k = 0; k < 8; k++) step(1, 8'(8'h20 + k), 4'(15 - k), 0, 0, '0, 0, a);
    for (int k = 0; k < 3; k++) begin
      step(1, 8'h28, 4'h7, 0, 0, '0, 0, a);
      chk("tp2_stall", 72'(a), 72'd0);
    end
    step(1, 8'h28, 4'h7, 0, 0, '0, 1, a);
    chk("tp2_accept", 72'(a), 72'd1);
    idle(1);
    idle(1);
    // Test 3: clear drops a partial vector.
    for (int k = 0; k < 4; k++) send(8'hE0 + 8'(k), 4'hF);
    step(1, 8'hEE, 4'hE, 1, 0, '0, 1, a);
    chk("tp3_clear_rdy", 72'(a), 72'd0);
    for (int k = 0; k < 9; k++) send(8'h30 + 8'(k), 4'(k + 3));
    idle(1);
    // Test 4: bias write on the completion beat.
    step(0, '0, '0, 0, 1, 5'd7, 1, a);
    for (int k = 0; k < 8; k++) send(8'h40 + 8'(k), 4'(k));
    step(1, 8'h48, 4'h8, 0, 1, 5'd3, 1, a);
    chk("tp4_accept", 72'(a), 72'd1);
    idle(1);
    chk("tp4_bias_old", 72'(out_exp_bias), 72'd7);
    for (int k = 0; k < 9; k++) send(8'h50 + 8'(k), 4'(9 - k));
    idle(1);
    chk("tp4_bias_new", 72'(out_exp_bias), 72'd3);
    // Test 5: reset mid-vector.
    for (int k = 0; k < 6; k++) send(8'hF0 + 8'(k), 4'hA);
    do_reset(2);
    for (int k = 0; k < 9; k++) send(8'h60 + 8'(k), 4'(k));
    idle(1);
    chk("tp5_image", out_image, 72'h686766656463626160);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom),
           $urandom_range(0, 40) == 0, $urandom_range(0, 9) == 0,
           5'($urandom), $urandom_range(0, 9) < 7, a);
    end
    n = 0;
    while (expq.size() > 0 && n < 20) begin
      idle(1);
      n++;
    end
    idle(1);
    chk("queue_empty", 72'(expq.size()), 72'd0);
`ifdef SD4_LOADER_VEC_COUNT_EN
    chk("vec_count", 72'(vec_count), 72'(16'(hs_cnt)));
    for (int k = 0; k < 9; k++) step(1, 8'(k), 4'(k), 0, 0, '0, 0, a);
    @(negedge clk);
    force dut.vcnt_q = 16'hFFFF;
    #1;
    release dut.vcnt_q;
    idle(1);
    idle(0);
    chk("vec_count_wrap", 72'(vec_count), 72'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
